// File: rtl/tcm_loader_pkg.sv
// Shared types for the TCM image loader.
//   state_t  : loader sequencer states
//   status_t : completion codes reported on status_o
//   lanes_of : byte lanes per TCM word for a given data width
package tcm_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_LOAD, ST_FLUSH, ST_RELEASE, ST_RUN, ST_END
  } state_t;

  typedef enum logic [1:0] {
    STAT_NONE     = 2'b00,
    STAT_FINISH   = 2'b01,
    STAT_TIMEOUT  = 2'b10,
    STAT_OVERFLOW = 2'b11
  } status_t;

  localparam int DEF_DATA_W = 32;
  localparam int LANES      = DEF_DATA_W / 8;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/tcm_image_loader_if.sv
// Image byte stream plus TCM word write port.
//   slave  : loader side (consumes bytes, drives the TCM port)
//   master : environment side (sources bytes, observes the TCM port)
interface tcm_image_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
);
  logic                  s_valid_i;
  logic [7:0]            s_data_i;
  logic                  s_ready_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_data_o;
  logic [DATA_W/8-1:0]   mem_be_o;

  modport slave (
    input  s_valid_i, s_data_i,
    output s_ready_o, mem_we_o, mem_addr_o, mem_data_o, mem_be_o
  );

  modport master (
    output s_valid_i, s_data_i,
    input  s_ready_o, mem_we_o, mem_addr_o, mem_data_o, mem_be_o
  );
endinterface

// File: rtl/tcm_byte_packer.sv
// Little-endian byte-to-word packer.
//   clr     : restart packing at lane 0 (new sequence)
//   take    : byte_in accepted this cycle
//   last    : accepted byte is the final byte of the image
//   wr      : this byte completes a word (full, or partial on last)
//   word/be : word to write when wr is set; be covers received lanes
module tcm_byte_packer
  import tcm_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                take,
  input  logic                last,
  input  logic [7:0]          byte_in,
  output logic                wr,
  output logic [DATA_W-1:0]   word,
  output logic [DATA_W/8-1:0] be
);
  localparam int NL = lanes_of(DATA_W);
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;

  logic [LW-1:0]     lane;
  logic [DATA_W-1:0] acc;

  // Merge the incoming byte into its lane; lanes above it are still empty.
  always_comb begin
    word = acc;
    be   = '0;
    for (int k = 0; k < NL; k++) begin
      if (LW'(k) == lane) word[8*k +: 8] = byte_in;
      be[k] = (LW'(k) <= lane);
    end
  end

  assign wr = take && ((lane == LW'(NL-1)) || last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane <= '0;
      acc  <= '0;
    end else if (take) begin
      if (wr) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + LW'(1);
        acc  <= word;
      end
    end
  end
endmodule

// File: rtl/tcm_image_loader.sv
// Boot / sim-control sequencer for the RISC-V TCM.
// Holds the core in reset, optionally zero-fills the TCM, streams a byte
// image into it, releases core reset after a hold time, then watches
// sim_finish_i with an optional cycle watchdog.
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : begin a sequence (honoured in IDLE / END only)
//   img_len_i      : image length in bytes, sampled on start_i
//   timeout_i      : run-cycle limit (0 = none), sampled on start_i
//   sim_finish_i   : finish flag from the core CSR file
//   core_rst_o     : core reset
//   busy_o/done_o  : sequence in progress / complete
//   status_o       : none / finished / timeout / overflow
//   bus            : image byte stream in, TCM write port out
module tcm_image_loader
  import tcm_loader_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 32768,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS),
  parameter int LEN_W       = ADDR_W + $clog2(DATA_W/8) + 1,
  parameter int CLEAR_EN    = 1,
  parameter int RST_HOLD    = 5,
  parameter int TMO_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     img_len_i,
  input  logic [TMO_W-1:0]     timeout_i,
  input  logic                 sim_finish_i,
  output logic                 core_rst_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           status_o,
  tcm_image_loader_if.slave    bus
);
  localparam int NL     = lanes_of(DATA_W);
  localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH_WORDS * NL);
  // With no hold time the core is released straight after the final write.
  localparam state_t REL_ST   = (RST_HOLD == 0) ? ST_RUN : ST_RELEASE;
  localparam logic   REL_CRST = (RST_HOLD != 0);

  state_t              state;
  status_t             status;
  logic [LEN_W-1:0]    len_q, byte_cnt;
  logic [TMO_W-1:0]    tmo_q, run_cnt;
  logic [ADDR_W-1:0]   word_idx, mem_addr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DATA_W-1:0]   mem_data;
  logic [NL-1:0]       mem_be;
  logic                mem_we, s_ready, core_rst, busy, done;

  logic                start_go, take, last, pk_wr;
  logic [DATA_W-1:0]   pk_word;
  logic [NL-1:0]       pk_be;

  assign start_go = start_i && (state == ST_IDLE || state == ST_END);
  assign take     = (state == ST_LOAD) && s_ready && bus.s_valid_i;
  assign last     = (byte_cnt == len_q - LEN_W'(1));

  tcm_byte_packer #(.DATA_W(DATA_W)) u_pack (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_go),
    .take    (take),
    .last    (last),
    .byte_in (bus.s_data_i),
    .wr      (pk_wr),
    .word    (pk_word),
    .be      (pk_be)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      status   <= STAT_NONE;
      len_q    <= '0;
      tmo_q    <= '0;
      byte_cnt <= '0;
      run_cnt  <= '0;
      word_idx <= '0;
      hold_cnt <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_be   <= '0;
      s_ready  <= 1'b0;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start_go) begin
        len_q    <= img_len_i;
        tmo_q    <= timeout_i;
        status   <= STAT_NONE;
        done     <= 1'b0;
        busy     <= 1'b1;
        core_rst <= 1'b1;
        s_ready  <= 1'b0;
        byte_cnt <= '0;
        word_idx <= '0;
        hold_cnt <= '0;
        run_cnt  <= '0;
        if (img_len_i > MAX_LEN) begin
          state  <= ST_END;
          status <= STAT_OVERFLOW;
          done   <= 1'b1;
          busy   <= 1'b0;
        end else if (CLEAR_EN != 0) begin
          state    <= ST_CLEAR;
          mem_we   <= 1'b1;
          mem_addr <= '0;
          mem_data <= '0;
          mem_be   <= '1;
        end else if (img_len_i == '0) begin
          state    <= REL_ST;
          core_rst <= REL_CRST;
        end else begin
          state   <= ST_LOAD;
          s_ready <= 1'b1;
        end
      end else begin
        case (state)
          ST_CLEAR: begin
            if (mem_addr == ADDR_W'(DEPTH_WORDS - 1)) begin
              if (len_q == '0) begin
                state    <= REL_ST;
                core_rst <= REL_CRST;
              end else begin
                state   <= ST_LOAD;
                s_ready <= 1'b1;
              end
            end else begin
              mem_we   <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
          ST_LOAD: begin
            if (take) begin
              if (byte_cnt != '1) byte_cnt <= byte_cnt + LEN_W'(1);
              if (pk_wr) begin
                mem_we   <= 1'b1;
                mem_addr <= word_idx;
                mem_data <= pk_word;
                mem_be   <= pk_be;
                if (word_idx != '1) word_idx <= word_idx + ADDR_W'(1);
              end
              if (last) begin
                s_ready <= 1'b0;
                state   <= ST_FLUSH;
              end
            end
          end
          // Final (possibly partial) word is on the port this cycle.
          ST_FLUSH: begin
            state    <= REL_ST;
            core_rst <= REL_CRST;
          end
          ST_RELEASE: begin
            if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
              state    <= ST_RUN;
              core_rst <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          // Finish is checked first so it wins a tie with the watchdog.
          ST_RUN: begin
            if (sim_finish_i) begin
              state  <= ST_END;
              status <= STAT_FINISH;
              done   <= 1'b1;
              busy   <= 1'b0;
            end else if (tmo_q != '0 && run_cnt == tmo_q - TMO_W'(1)) begin
              state    <= ST_END;
              status   <= STAT_TIMEOUT;
              done     <= 1'b1;
              busy     <= 1'b0;
              core_rst <= 1'b1;
            end else if (run_cnt != '1) begin
              run_cnt <= run_cnt + TMO_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.s_ready_o  = s_ready;
  assign bus.mem_we_o   = mem_we;
  assign bus.mem_addr_o = mem_addr;
  assign bus.mem_data_o = mem_data;
  assign bus.mem_be_o   = mem_be;
  assign core_rst_o     = core_rst;
  assign busy_o         = busy;
  assign done_o         = done;
  assign status_o       = status;
endmodule

// File: tb/tb_tcm_image_loader.sv
// Self-checking bench for tcm_image_loader (DEPTH_WORDS=16, DATA_W=32,
// CLEAR_EN=1, RST_HOLD=5). Table of load/run scenarios plus hand-written
// overflow and mid-load reset sequences.
module tb_tcm_image_loader;
  localparam int DW = 32, DEPTH = 16, AW = 4, LW = 7, HOLD = 5;

  logic          clk, rst, start_i, sim_finish_i;
  logic [LW-1:0] img_len_i;
  logic [31:0]   timeout_i;
  logic          core_rst_o, busy_o, done_o;
  logic [1:0]    status_o;

  tcm_image_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  tcm_image_loader #(
    .DATA_W(DW), .DEPTH_WORDS(DEPTH), .CLEAR_EN(1), .RST_HOLD(HOLD), .TMO_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .img_len_i(img_len_i),
    .timeout_i(timeout_i), .sim_finish_i(sim_finish_i), .core_rst_o(core_rst_o),
    .busy_o(busy_o), .done_o(done_o), .status_o(status_o), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    be;
  } wr_t;

  typedef struct {
    int         len;
    logic [7:0] base;
    int         tmo;
    int         fin_at;   // cycles after release to pulse finish, -1 = never
    bit         gaps;
    logic [1:0] exp_st;
    logic       exp_crst;
    int         exp_run;  // cycles from release to done rising
  } vec_t;

  int  n_chk = 0, n_fail = 0;
  int  cyc = 0, last_we_cyc = -1, fall_cyc = -1, done_cyc = -1, rdy_cnt = 0;
  bit  prev_crst = 1'b1, prev_done = 1'b0;
  wr_t wq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observer, sampled 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mem_we_o === 1'b1) begin
      wq.push_back('{a: bus.mem_addr_o, d: bus.mem_data_o, be: bus.mem_be_o});
      last_we_cyc = cyc;
    end
    if (bus.s_ready_o === 1'b1) rdy_cnt++;
    if (prev_crst && core_rst_o === 1'b0) fall_cyc = cyc;
    prev_crst = (core_rst_o !== 1'b0);
    if (!prev_done && done_o === 1'b1) done_cyc = cyc;
    prev_done = (done_o === 1'b1);
  end

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0] b [$];
    wr_t        ex [$];
    logic [31:0] d;
    logic [3:0]  be;
    int g, idx;
    bit take;
    for (int i = 0; i < v.len; i++) b.push_back(v.base + 8'(i));
    for (int i = 0; i < DEPTH; i++) ex.push_back('{a: AW'(i), d: 32'h0, be: 4'hF});
    for (int i = 0; i < v.len; i += 4) begin
      d = '0; be = '0;
      for (int k = 0; k < 4 && i + k < v.len; k++) begin
        d[8*k +: 8] = b[i+k];
        be[k] = 1'b1;
      end
      ex.push_back('{a: AW'(i/4), d: d, be: be});
    end

    @(negedge clk);
    wq.delete(); last_we_cyc = -1; fall_cyc = -1; done_cyc = -1; rdy_cnt = 0;
    start_i = 1'b1; img_len_i = LW'(v.len); timeout_i = v.tmo;
    @(negedge clk);
    start_i = 1'b0;
    chk($sformatf("v%0d busy_at_start", id), busy_o, 1);
    chk($sformatf("v%0d done_cleared", id), done_o, 0);

    idx = 0; take = 0; g = 0;
    while (idx < v.len && g < 3000) begin
      @(negedge clk); g++;
      if (take) idx++;
      if (idx < v.len) begin
        bus.s_valid_i = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.s_data_i  = b[idx];
      end else begin
        bus.s_valid_i = 1'b0;
      end
      take = bus.s_valid_i && bus.s_ready_o;
    end
    chk($sformatf("v%0d bytes_sent", id), idx, v.len);

    g = 0;
    while (core_rst_o !== 1'b0 && g < 500) begin @(negedge clk); g++; end
    chk($sformatf("v%0d core_rst_fall", id), core_rst_o, 0);
    if (v.fin_at >= 0) begin
      repeat (v.fin_at) @(negedge clk);
      sim_finish_i = 1'b1;
      @(negedge clk);
      sim_finish_i = 1'b0;
    end
    g = 0;
    while (done_o !== 1'b1 && g < 3000) begin @(negedge clk); g++; end
    chk($sformatf("v%0d done", id), done_o, 1);
    chk($sformatf("v%0d busy_end", id), busy_o, 0);
    chk($sformatf("v%0d status", id), status_o, v.exp_st);
    chk($sformatf("v%0d core_rst_end", id), core_rst_o, v.exp_crst);
    chk($sformatf("v%0d hold_cycles", id), fall_cyc - last_we_cyc - 1, HOLD);
    chk($sformatf("v%0d run_cycles", id), done_cyc - fall_cyc, v.exp_run);
    if (!v.gaps) chk($sformatf("v%0d ready_cycles", id), rdy_cnt, v.len);
    chk($sformatf("v%0d n_writes", id), wq.size(), ex.size());
    for (int i = 0; i < ex.size() && i < wq.size(); i++) begin
      chk($sformatf("v%0d w%0d addr", id, i), wq[i].a, ex[i].a);
      chk($sformatf("v%0d w%0d be", id, i), wq[i].be, ex[i].be);
      chk($sformatf("v%0d w%0d data", id, i), wq[i].d & be_mask(ex[i].be),
          ex[i].d & be_mask(ex[i].be));
    end
  endtask

  vec_t vt [6];

  initial begin
    vt[0] = '{len: 0,  base: 8'h00, tmo: 0,    fin_at: 20,  gaps: 0, exp_st: 2'b01, exp_crst: 0, exp_run: 21};
    vt[1] = '{len: 8,  base: 8'h01, tmo: 1000, fin_at: 100, gaps: 0, exp_st: 2'b01, exp_crst: 0, exp_run: 101};
    vt[2] = '{len: 6,  base: 8'hAA, tmo: 1000, fin_at: 100, gaps: 1, exp_st: 2'b01, exp_crst: 0, exp_run: 101};
    vt[3] = '{len: 5,  base: 8'h10, tmo: 50,   fin_at: -1,  gaps: 0, exp_st: 2'b10, exp_crst: 1, exp_run: 50};
    vt[4] = '{len: 4,  base: 8'h20, tmo: 50,   fin_at: 49,  gaps: 1, exp_st: 2'b01, exp_crst: 0, exp_run: 50};
    vt[5] = '{len: 64, base: 8'h40, tmo: 3,    fin_at: -1,  gaps: 0, exp_st: 2'b10, exp_crst: 1, exp_run: 3};

    rst = 1'b1; start_i = 1'b0; img_len_i = '0; timeout_i = '0; sim_finish_i = 1'b0;
    bus.s_valid_i = 1'b0; bus.s_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst core_rst", core_rst_o, 1);
    chk("rst ready", bus.s_ready_o, 0);
    chk("rst we", bus.mem_we_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst status", status_o, 0);
    chk("rst addr", bus.mem_addr_o, 0);
    chk("rst data", bus.mem_data_o, 0);
    chk("rst be", bus.mem_be_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(vt[i], i);
      if (i == 1 && wq.size() >= 18) begin
        chk("full word0", wq[16].d, 32'h04030201);
        chk("full word1", wq[17].d, 32'h08070605);
      end
      if (i == 2 && wq.size() >= 18) begin
        chk("partial be", wq[17].be, 4'b0011);
        chk("partial low", wq[17].d[15:0], 16'hAFAE);
      end
    end

    // Overflow: one byte past capacity ends immediately with no writes.
    @(negedge clk);
    wq.delete();
    start_i = 1'b1; img_len_i = LW'(DEPTH*4 + 1); timeout_i = 32'd10;
    @(negedge clk);
    start_i = 1'b0;
    chk("ovf status", status_o, 2'b11);
    chk("ovf done", done_o, 1);
    chk("ovf busy", busy_o, 0);
    chk("ovf core_rst", core_rst_o, 1);
    repeat (4) @(negedge clk);
    chk("ovf no_writes", wq.size(), 0);

    // Reset in the middle of LOAD.
    start_i = 1'b1; img_len_i = LW'(8); timeout_i = 32'd1000;
    @(negedge clk);
    start_i = 1'b0;
    for (int g = 0; g < 100 && bus.s_ready_o !== 1'b1; g++) @(negedge clk);
    chk("mid ready_seen", bus.s_ready_o, 1);
    bus.s_valid_i = 1'b1; bus.s_data_i = 8'h55;
    repeat (3) @(negedge clk);
    rst = 1'b1; bus.s_valid_i = 1'b0;
    @(negedge clk);
    chk("midrst core_rst", core_rst_o, 1);
    chk("midrst ready", bus.s_ready_o, 0);
    chk("midrst we", bus.mem_we_o, 0);
    chk("midrst busy", busy_o, 0);
    chk("midrst done", done_o, 0);
    chk("midrst status", status_o, 0);
    chk("midrst addr", bus.mem_addr_o, 0);
    chk("midrst data", bus.mem_data_o, 0);
    chk("midrst be", bus.mem_be_o, 0);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vt[1], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tcm_image_loader.md
Name: tcm_image_loader

Overview:
Synthesisable boot/sim-control block for the RISC-V TCM.
- Holds the core in reset and optionally zero-fills the TCM.
- Streams a byte image (little-endian) into the TCM word port, then releases core reset.
- Monitors the CSR sim_finish flag with a programmable cycle watchdog and reports completion status.
- Replaces fixed-size bench-side memory preloading.

Parameters:
DATA_W, 32, TCM word width in bits; multiple of 8.
DEPTH_WORDS, 32768, TCM depth in words (128 KiB at DATA_W=32).
ADDR_W, clog2(DEPTH_WORDS), word address width (derived).
LEN_W, ADDR_W+clog2(DATA_W/8)+1, byte-length width (derived).
CLEAR_EN, 1, 1 = zero-fill the whole TCM before loading.
RST_HOLD, 5, cycles core_rst_o stays high after the last TCM write.
TMO_W, 32, watchdog counter width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_i  in  1  one-cycle pulse; begins a load/run sequence
img_len_i  in  LEN_W  image length in bytes; sampled on start_i
timeout_i  in  TMO_W  run-cycle limit; 0 = no watchdog; sampled on start_i
s_valid_i  in  1  image byte valid
s_data_i  in  8  image byte
s_ready_o  out  1  image byte accepted when s_valid_i & s_ready_o
mem_we_o  out  1  TCM write strobe
mem_addr_o  out  ADDR_W  TCM word address
mem_data_o  out  DATA_W  TCM write data
mem_be_o  out  DATA_W/8  TCM byte enables
core_rst_o  out  1  reset to core; high while loading
sim_finish_i  in  1  core finish flag from CSR file
busy_o  out  1  sequence in progress
done_o  out  1  sequence complete; held until next start_i
status_o  out  2  00 none, 01 finished, 10 timeout, 11 overflow

Behaviour:
- Reset values:
  - core_rst_o=1.
  - s_ready_o, mem_we_o, busy_o and done_o are 0.
  - status_o=00.
  - mem_addr_o, mem_data_o and mem_be_o are 0.
  - All counters are 0; state is IDLE.
- States: IDLE, CLEAR, LOAD, FLUSH, RELEASE, RUN, END.
- IDLE:
  - On start_i, latch img_len_i and timeout_i; clear done_o and status_o; set busy_o. core_rst_o=1.
  - If img_len_i > DEPTH_WORDS*DATA_W/8, go to END with status 11. No writes occur.
  - Otherwise go to CLEAR if CLEAR_EN=1, else LOAD.
  - start_i is ignored in every state except IDLE and END.
- CLEAR:
  - One write per cycle: mem_we_o=1, data 0, be all ones, addr 0..DEPTH_WORDS-1. Takes DEPTH_WORDS cycles.
  - Then go to LOAD, or to RELEASE if the latched length is 0.
- LOAD:
  - s_ready_o=1.
  - Accepted bytes are packed little-endian; byte k lands in lane k mod (DATA_W/8).
  - The completing byte of a word issues mem_we_o the following cycle, with be all ones and addr = word index starting at 0.
  - s_ready_o stays high during that write cycle, so there are no bubbles.
  - On the last image byte, any partial word is written with be covering only the received lanes (FLUSH, 1 cycle).
  - s_valid_i gaps simply stall; there is no timeout in LOAD.
- RELEASE:
  - core_rst_o stays high for RST_HOLD cycles after the final write, then drops to 0.
  - Enter RUN the same cycle it drops.
- RUN:
  - The cycle counter increments each cycle from 0.
  - If sim_finish_i=1, go to END with status 01.
  - Else if timeout_i≠0 and counter == timeout_i-1, go to END with status 10.
  - If finish and timeout occur in the same cycle, finish wins.
- END:
  - done_o=1, busy_o=0.
  - core_rst_o is 0 for status 01 and 1 for status 10/11; a timed-out core is halted.
  - start_i restarts directly (same actions as IDLE start).
- Reset mid-operation: immediate return to reset values. A partially written TCM is not restored.
- Counters saturate and never wrap. The address counter is bounded by the overflow check.

Decomposition:
- Shared package tcm_loader_pkg:
  - state enum.
  - status codes STAT_NONE/FINISH/TIMEOUT/OVERFLOW.
  - Lane-count constant DATA_W/8.
- One sub-module, tcm_byte_packer: byte to DATA_W word packing, lane counter, partial-flush byte-enable generation.
- The top level holds the FSM, address counter, hold counter and watchdog.

Test Plan:
- Zero-fill check: CLEAR_EN=1, DEPTH_WORDS=16, img_len=0, timeout=0.
  - Expect 16 writes: addr 0..15, data 0, be 4'hF.
  - core_rst_o falls 5 cycles after the last write; no s_ready_o.
- Full-word load: img_len=8, bytes 01..08 back-to-back.
  - Expect writes addr0=32'h04030201 and addr1=32'h08070605, both be=F.
  - s_ready_o high throughout with no stall.
- Partial word: img_len=6, bytes AA..AF with random s_valid_i gaps.
  - Expect addr1 data low half 16'hAFAE with be=4'b0011.
- Finish path: sim_finish_i pulses 100 cycles after release, timeout=1000.
  - Expect status 01, done_o=1, core_rst_o=0.
- Watchdog edge cases:
  - timeout=50, no finish: status 10 exactly 50 cycles after release, core_rst_o=1.
  - Finish and timeout in the same cycle: status 01.
- Overflow and reset:
  - img_len=DEPTH_WORDS*4+1: status 11 next cycle, zero writes.
  - rst asserted mid-LOAD: all outputs return to reset values next cycle.
  - A subsequent start_i completes normally.
